ram_led_unit: RTL and testbench



---
 rtl/ram_led_unit_pkg.sv | 57 +++++
 rtl/ram_led_unit_led_decoder.sv | 36 +++
 rtl/ram_led_unit.sv | 98 +++++++++
 tb/tb_ram_led_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ram_led_unit_pkg.sv
// Shared types and constants for the SRAM access unit and its seven-segment decoder.
// Optional LED_HEX_EN (used by led_decoder) enables A-F glyphs for index 10-15.
package ram_led_unit_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int ADDR_EXT_W = 2;
  localparam int RAM_ADDR_W = ADDR_W + ADDR_EXT_W;
  localparam int IDX_W      = 4;
  localparam int SEG_W      = 7;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_SETUP,
    RD_WAIT,
    RD_SAMPLE
  } state_t;

  // Request fields captured when the FSM leaves IDLE.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_req_t;

  // SRAM strobes are active-low; drive enables the write data onto RamData.
  typedef struct packed {
    logic en_n;
    logic oe_n;
    logic we_n;
    logic drive;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_CTL_IDLE = '{en_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, drive: 1'b0};

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/ram_led_unit_led_decoder.sv
// Combinational 4-bit to seven-segment decoder.
// LED_HEX_EN defined: 10-15 render A..F; otherwise they are blank.
module led_decoder
  import ram_led_unit_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output logic [SEG_W-1:0] led
);

  always_comb begin
    led = SEG_BLANK;
    case (index)
      4'd0:  led = SEG_0;
      4'd1:  led = SEG_1;
      4'd2:  led = SEG_2;
      4'd3:  led = SEG_3;
      4'd4:  led = SEG_4;
      4'd5:  led = SEG_5;
      4'd6:  led = SEG_6;
      4'd7:  led = SEG_7;
      4'd8:  led = SEG_8;
      4'd9:  led = SEG_9;
`ifdef LED_HEX_EN
      4'd10: led = SEG_A;
      4'd11: led = SEG_B;
      4'd12: led = SEG_C;
      4'd13: led = SEG_D;
      4'd14: led = SEG_E;
      4'd15: led = SEG_F;
`else
      default: led = SEG_BLANK;
`endif
    endcase
  end

endmodule

// File: rtl/ram_led_unit.sv
// Sequences one-cycle requests into 3-cycle async SRAM reads/writes, plus a 7-seg display decoder.
// Build option LED_HEX_EN (see led_decoder) selects hex glyphs for display values 10-15.
module ram_led_unit
  import ram_led_unit_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  busy,
  output logic                  done,
  output logic [RAM_ADDR_W-1:0] RamAddr,
  inout  wire  [DATA_W-1:0]     RamData,
  output logic                  RamOE,
  output logic                  RamWE,
  output logic                  RamEN,
  input  logic [IDX_W-1:0]      index,
  output logic [SEG_W-1:0]      led
);

  state_t    state_q, state_d;
  acc_req_t  acc_q;
  sram_ctl_t ctl;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      acc_q   <= '0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      // Only IDLE accepts a request, so a strobe during an access is dropped.
      if (state_q == IDLE && req)
        acc_q <= '{addr: addr, wdata: data_i};
      if (state_q == RD_SAMPLE)
        data_o <= RamData;
    end
  end

  always_comb begin
    state_d = state_q;
    ctl     = SRAM_CTL_IDLE;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req)
          state_d = read ? RD_SETUP : WR_SETUP;
      end
      WR_SETUP: begin
        ctl     = '{en_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, drive: 1'b1};
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        ctl     = '{en_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, drive: 1'b1};
        state_d = WR_HOLD;
      end
      WR_HOLD: begin
        ctl     = '{en_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, drive: 1'b1};
        done    = 1'b1;
        state_d = IDLE;
      end
      RD_SETUP: begin
        ctl     = '{en_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, drive: 1'b0};
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        ctl     = '{en_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, drive: 1'b0};
        state_d = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        ctl     = '{en_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, drive: 1'b0};
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign RamEN   = ctl.en_n;
  assign RamOE   = ctl.oe_n;
  assign RamWE   = ctl.we_n;
  assign RamAddr = {{ADDR_EXT_W{1'b0}}, acc_q.addr};
  assign RamData = ctl.drive ? acc_q.wdata : {DATA_W{1'bz}};

  led_decoder u_led_decoder (
    .index (index),
    .led   (led)
  );

endmodule

// File: tb/tb_ram_led_unit.sv
// Directed bench for ram_led_unit with a behavioural SRAM and a read-data scoreboard queue.
module tb_ram_led_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req = 1'b0;
  logic        read = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] data_i = 16'h0;
  logic [15:0] data_o;
  logic        busy, done;
  logic [17:0] RamAddr;
  tri1  [15:0] RamData;
  logic        RamOE, RamWE, RamEN;
  logic [3:0]  index = 4'h0;
  logic [6:0]  led;

  int total = 0;
  int bad   = 0;
  logic [15:0] rdq[$];
  logic [15:0] sram [0:255];

  ram_led_unit dut (
    .CLK(CLK), .RST(RST), .req(req), .read(read), .addr(addr), .data_i(data_i),
    .data_o(data_o), .busy(busy), .done(done), .RamAddr(RamAddr), .RamData(RamData),
    .RamOE(RamOE), .RamWE(RamWE), .RamEN(RamEN), .index(index), .led(led)
  );

  always #5 CLK = ~CLK;

  // Behavioural SRAM: drives the bus while selected with OE low, writes while WE low.
  assign RamData = (!RamEN && !RamOE) ? sram[RamAddr[7:0]] : 16'hzzzz;
  always @(posedge CLK)
    if (!RamEN && !RamWE) sram[RamAddr[7:0]] <= RamData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [6:0] exp_led(input int i);
    case (i)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
`ifdef LED_HEX_EN
      10: return 7'h77; 11: return 7'h7C; 12: return 7'h39;
      13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
`endif
      default: return 7'h00;
    endcase
  endfunction

  // Issue one access from an IDLE cycle and follow it to the IDLE cycle after done.
  // For reads, d is the value the SRAM should return; poke fires a stray req mid-access.
  task automatic access(input bit rd, input logic [15:0] a, input logic [15:0] d, input bit poke);
    int  cyc, we_lo, oe_lo;
    bit  seen_done;
    req = 1'b1; read = rd; addr = a; data_i = d;
    if (rd) rdq.push_back(d);
    tick();
    req = 1'b0; addr = 16'hFFFF; data_i = 16'h5A5A;
    cyc = 0; we_lo = 0; oe_lo = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 8) begin
      cyc++;
      chk("busy", busy, 1);
      chk("ram_addr", RamAddr, {2'b00, a});
      chk("ram_en", RamEN, 0);
      chk("ram_bus", RamData, d);
      if (!RamWE) we_lo++;
      if (!RamOE) oe_lo++;
      if (done) begin
        seen_done = 1'b1;
        chk("done_cycle", cyc, 3);
      end
      req = (poke && cyc == 2);
      read = 1'b0; addr = a; data_i = 16'hDEAD;
      tick();
    end
    req = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("we_low_cycles", we_lo, rd ? 0 : 1);
    chk("oe_low_cycles", oe_lo, rd ? 3 : 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_bus", RamData, 16'hFFFF);
    chk("idle_ctl", {RamEN, RamOE, RamWE}, 3'b111);
    chk("idle_addr", RamAddr, {2'b00, a});
    if (rd) chk("data_o", data_o, rdq.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    tick();
    tick();
    chk("rst_ctl", {RamEN, RamOE, RamWE}, 3'b111);
    chk("rst_bus", RamData, 16'hFFFF);
    chk("rst_data_o", data_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", RamAddr, 0);
    RST = 1'b0;
    tick();

    access(1'b0, 16'h0010, 16'h1234, 1'b0);
    access(1'b1, 16'h0010, 16'h1234, 1'b0);

    for (int i = 0; i < 10; i++)
      access(1'b0, 16'(i), 16'(i + 16'h00A0), i == 3);
    for (int i = 0; i < 10; i++)
      access(1'b1, 16'(i), 16'(i + 16'h00A0), 1'b0);
    chk("queue_empty", rdq.size(), 0);

    // Abort a write while WE is low.
    req = 1'b1; read = 1'b0; addr = 16'h0055; data_i = 16'h0BEE;
    tick();
    req = 1'b0;
    tick();
    chk("abort_in_pulse", RamWE, 0);
    RST = 1'b1;
    tick();
    chk("abort_we", RamWE, 1);
    chk("abort_oe", RamOE, 1);
    chk("abort_bus", RamData, 16'hFFFF);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", RamAddr, 0);
    RST = 1'b0;
    tick();
    access(1'b0, 16'h0020, 16'h7777, 1'b0);
    access(1'b1, 16'h0020, 16'h7777, 1'b0);

    for (int i = 0; i < 16; i++) begin
      index = 4'(i);
      #1;
      chk($sformatf("led_%0d", i), led, exp_led(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
